// File: rtl/seq_event_monitor_pkg.sv
// Shared FSM encoding and default parameters for the windowed event monitor.
package seq_event_monitor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int DEF_WIN_LEN = 16;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_THRESH  = 3;
  localparam int TMR_W       = 8;  // covers WIN_LEN up to 255

endpackage

// File: rtl/seq_event_monitor_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)                q_d = '0;
    else if (inc && !(&q_q)) q_d = q_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_event_monitor.sv
// Counts upstream detector pulses over fixed windows and hands each window's
// count to a valid/ready consumer, flagging alarms and dropped results.
module seq_event_monitor
  import seq_event_monitor_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int THRESH  = DEF_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             z_in,
  input  logic [1:0]       y_in,
  input  logic             clr,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [CNT_W-1:0] win_count,
  output logic             alarm,
  output logic [1:0]       last_y,
  output logic             overrun
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] run_cnt, fin_cnt;
  logic             cnt_clr, cnt_inc, win_end;
  logic             valid_q, alarm_q, ovr_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       last_y_q;
  logic             load, drop, take;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    win_end = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        state_d = COUNT;
        tmr_d   = '0;
        cnt_clr = 1'b1;
      end
      COUNT: begin
        if (!en) begin
          state_d = IDLE;
          tmr_d   = '0;
          cnt_clr = 1'b1;
        end else if (tmr_q == TMR_LAST) begin
          // last-cycle event is folded into fin_cnt, counter restarts for the new window
          win_end = 1'b1;
          tmr_d   = '0;
          cnt_clr = 1'b1;
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
          cnt_inc = z_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (run_cnt)
  );

  assign fin_cnt = (&run_cnt) ? run_cnt : run_cnt + CNT_W'(z_in);
  assign take    = valid_q & win_ready;
  assign load    = win_end & (~valid_q | win_ready);
  assign drop    = win_end & valid_q & ~win_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      count_q  <= '0;
      alarm_q  <= 1'b0;
      ovr_q    <= 1'b0;
      last_y_q <= 2'b00;
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        count_q <= fin_cnt;
        alarm_q <= (int'(fin_cnt) >= THRESH);
      end else if (take) begin
        valid_q <= 1'b0;
        alarm_q <= 1'b0;
      end
      if (drop)     ovr_q <= 1'b1;
      else if (clr) ovr_q <= 1'b0;
      if (z_in) last_y_q <= y_in;
    end
  end

  assign win_valid = valid_q;
  assign win_count = count_q;
  assign alarm     = alarm_q;
  assign overrun   = ovr_q;
  assign last_y    = last_y_q;

endmodule

// File: tb/tb_seq_event_monitor.sv
// Bench: vector table, directed corner sequences and random traffic against a window-level reference model.
module tb_seq_event_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, z_in, clr, win_ready;
  logic [1:0] y_in;
  logic       v1, a1, o1, v2, a2, o2;
  logic [7:0] c1;
  logic [1:0] c2, ly1, ly2;

  seq_event_monitor #(.WIN_LEN(8), .CNT_W(8), .THRESH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .z_in(z_in), .y_in(y_in), .clr(clr),
    .win_valid(v1), .win_ready(win_ready), .win_count(c1), .alarm(a1),
    .last_y(ly1), .overrun(o1));

  seq_event_monitor #(.WIN_LEN(8), .CNT_W(2), .THRESH(3)) dut2 (
    .clk(clk), .rst(rst), .en(en), .z_in(z_in), .y_in(y_in), .clr(clr),
    .win_valid(v2), .win_ready(win_ready), .win_count(c2), .alarm(a2),
    .last_y(ly2), .overrun(o2));

  int checks = 0, failures = 0;

  // reference: window position, raw (unbounded) event total, pending result
  bit         m_act, m_valid, m_ovr;
  int         m_pos, m_raw, m_cnt;
  logic [1:0] m_ly;

  typedef struct {
    bit rst, en, z; bit [1:0] y; bit clr, rdy;
    bit v; int cnt; bit al, ov;
  } vec_t;
  vec_t tbl[$];

  function automatic int sat(int x, int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit done, drop; int res;
    done = 0; drop = 0; res = 0;
    if (!rst) begin
      m_act = 0; m_pos = 0; m_raw = 0; m_valid = 0; m_cnt = 0; m_ovr = 0; m_ly = 2'b00;
    end else begin
      if (m_act) begin
        if (!en) m_act = 0;
        else begin
          m_raw += int'(z_in);
          if (m_pos == 7) begin done = 1; res = m_raw; m_raw = 0; m_pos = 0; end
          else m_pos++;
        end
      end else if (en) begin
        m_act = 1; m_pos = 0; m_raw = 0;
      end
      if (done && m_valid && !win_ready) drop = 1;
      else if (done) begin m_valid = 1; m_cnt = res; end
      else if (m_valid && win_ready) m_valid = 0;
      if (drop) m_ovr = 1; else if (clr) m_ovr = 0;
      if (z_in) m_ly = y_in;
    end
  endtask

  task automatic cmp_model();
    chk("m_valid",    v1,  m_valid);
    chk("m_count",    c1,  sat(m_cnt, 255));
    chk("m_alarm",    a1,  m_valid && sat(m_cnt, 255) >= 3);
    chk("m_last_y",   ly1, m_ly);
    chk("m_overrun",  o1,  m_ovr);
    chk("m_valid2",   v2,  m_valid);
    chk("m_count2",   c2,  sat(m_cnt, 3));
    chk("m_alarm2",   a2,  m_valid && sat(m_cnt, 3) >= 3);
    chk("m_overrun2", o2,  m_ovr);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  task automatic drive(bit r, bit e, bit z, bit [1:0] y, bit c, bit rd);
    rst = r; en = e; z_in = z; y_in = y; clr = c; win_ready = rd;
    step();
  endtask

  function automatic void add(bit r, bit e, bit z, bit [1:0] y, bit c, bit rd,
                              bit v, int cnt, bit al, bit ov);
    vec_t t;
    t.rst = r; t.en = e; t.z = z; t.y = y; t.clr = c; t.rdy = rd;
    t.v = v; t.cnt = cnt; t.al = al; t.ov = ov;
    tbl.push_back(t);
  endfunction

  // upstream Mealy "101" detector (overlapping); y = current state code
  bit [1:0] ds;
  bit       A[7];

  initial begin
    int n_pulse; logic [1:0] exp_ly; bit zz; bit sawv;
    rst = 0; en = 0; z_in = 0; y_in = 0; clr = 0; win_ready = 1;

    // basic window: events on cycles 1, 3, 7
    add(0,0,0,0,0,1, 0,0,0,0);
    add(1,1,0,0,0,1, 0,0,0,0);
    for (int i = 0; i < 8; i++)
      add(1,1, (i==1)||(i==3)||(i==7), 2'(i), 0,1, (i==7), (i==7) ? 3 : 0, (i==7), 0);
    add(1,1,0,0,0,1, 0,3,0,0);
    add(1,0,0,0,0,1, 0,3,0,0);
    // boundary: event on last cycle and on first cycle of the next window
    add(1,1,0,0,0,1, 0,3,0,0);
    for (int i = 0; i < 7; i++) add(1,1,0,0,0,1, 0,3,0,0);
    add(1,1,1,2,0,1, 1,1,0,0);
    add(1,1,1,1,0,1, 0,1,0,0);
    for (int i = 1; i < 7; i++) add(1,1,0,0,0,1, 0,1,0,0);
    add(1,1,0,0,0,1, 1,1,0,0);
    add(1,0,0,0,0,1, 0,1,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].z, tbl[i].y, tbl[i].clr, tbl[i].rdy);
      chk("tbl_valid",   v1, tbl[i].v);
      chk("tbl_count",   c1, tbl[i].cnt);
      chk("tbl_alarm",   a1, tbl[i].al);
      chk("tbl_overrun", o1, tbl[i].ov);
    end

    // backpressure across two windows, then clear the sticky flag
    drive(0,0,0,0,0,0);
    drive(1,1,0,0,0,0);
    for (int i = 0; i < 8; i++) drive(1,1, i==2, 0, 0,0);
    for (int i = 0; i < 8; i++) drive(1,1, 1, 1, 0,0);
    chk("bp_valid", v1, 1); chk("bp_count", c1, 1); chk("bp_overrun", o1, 1);
    drive(1,0,0,0,1,0);
    chk("clr_overrun", o1, 0); chk("clr_held", c1, 1);
    drive(1,0,0,0,0,1);
    chk("bp_drain", v1, 0);

    // saturation on the narrow counter
    drive(0,0,0,0,0,1);
    drive(1,1,0,0,0,1);
    for (int i = 0; i < 8; i++) drive(1,1,1,0,0,1);
    chk("sat_count2", c2, 3); chk("sat_alarm2", a2, 1); chk("sat_count", c1, 8);

    // abort mid-window gives no result
    drive(0,0,0,0,0,1);
    drive(1,1,0,0,0,1);
    for (int i = 0; i < 4; i++) drive(1,1,1,0,0,1);
    sawv = 0;
    for (int i = 0; i < 10; i++) begin drive(1,0,0,0,0,1); sawv |= v1; end
    chk("abort_novalid", sawv, 0);

    // reset while a result is pending
    drive(1,1,0,0,0,0);
    for (int i = 0; i < 8; i++) drive(1,1, i<4, 3, 0,0);
    chk("pre_rst_valid", v1, 1); chk("pre_rst_ly", ly1, 3);
    drive(0,1,1,2,0,0);
    chk("rst_valid", v1, 0); chk("rst_count", c1, 0); chk("rst_alarm", a1, 0);
    chk("rst_last_y", ly1, 0); chk("rst_overrun", o1, 0);

    // upstream detector link
    A = '{1,0,1,0,1,1,1};
    drive(1,1,0,0,0,1);
    ds = 0; n_pulse = 0; exp_ly = 0;
    for (int i = 0; i < 7; i++) begin
      zz = (ds == 2) && A[i];
      if (zz) begin n_pulse++; exp_ly = ds; end
      drive(1,1, zz, ds, 0,1);
      ds = A[i] ? 2'd1 : ((ds == 1) ? 2'd2 : 2'd0);
    end
    drive(1,1,0,ds,0,1);
    chk("link_pulses", n_pulse, 2);
    chk("link_count", c1, n_pulse); chk("link_valid", v1, 1);
    chk("link_last_y", ly1, exp_ly);

    // random traffic against the model
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(199) != 0), ($urandom_range(29) != 0),
            ($urandom_range(2) == 0), 2'($urandom), ($urandom_range(19) == 0),
            ($urandom_range(1) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_event_monitor.md
SEQ_EVENT_MONITOR -- requirements
Module: seq_event_monitor

Parameters
REQ-001 WIN_LEN, 16: window length in clock cycles; legal range 2..255.
REQ-002 CNT_W, 8: width of the event count.
REQ-003 THRESH, 3: alarm threshold; an alarm fires when the window count is >= THRESH.

Interface
REQ-004 clk  in  1  rising-edge system clock; the only clock.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 en  in  1  monitor enable.
REQ-007 z_in  in  1  detection output Z of the upstream Mealy sequence detector.
REQ-008 y_in  in  2  state code y of the upstream detector.
REQ-009 clr  in  1  clears the sticky flags.
REQ-010 win_valid  out  1  window result available.
REQ-011 win_ready  in  1  consumer accepts the window result.
REQ-012 win_count  out  CNT_W  count of events in the completed window.
REQ-013 alarm  out  1  completed window count >= THRESH; qualified by win_valid.
REQ-014 last_y  out  2  y_in captured at the most recent event.
REQ-015 overrun  out  1  sticky; set when a window result was dropped.

Function
REQ-016 An event is a rising clk edge with z_in=1; every such cycle counts one event, so consecutive high cycles count separately.
REQ-017 The FSM has two states, IDLE and COUNT; reset enters IDLE.
REQ-018 IDLE -> COUNT on the edge that samples en=1; the window timer and the running count both load 0.
REQ-019 In COUNT the window timer advances 0..WIN_LEN-1; the cycle with timer=WIN_LEN-1 is the last cycle of the window, and an event in that cycle belongs to the ending window.
REQ-020 At the end of a window: the timer wraps to 0 and the FSM stays in COUNT if en=1; an event in the first cycle of the new window counts in the new window.
REQ-021 COUNT with en=0 sampled: abort to IDLE and discard the partial count; this produces no result and no overrun.
REQ-022 The running count saturates at 2^CNT_W-1 and does not wrap.
REQ-023 At window end the final count, including any event in the last cycle, is registered into win_count, and win_valid rises on the next cycle (latency 1).
REQ-024 alarm = (win_count >= THRESH), registered together with win_count; alarm=0 whenever win_valid=0.
REQ-025 win_valid, win_count and alarm hold stable until a cycle with win_valid=1 and win_ready=1; win_valid falls on the next edge.
REQ-026 Window completes while win_valid=1 and win_ready=0: the new result is dropped, the held result is unchanged and overrun is set.
REQ-027 Window completes in the same cycle as the handshake: the new result is loaded, win_valid stays 1 and no overrun occurs.
REQ-028 last_y is loaded with y_in on every event, in any state, and holds between events.
REQ-029 clr=1 clears overrun on the next edge; clr and a new overrun in the same cycle leave overrun=1.
REQ-030 The monitor passes no combinational path from any input to any output.

Reset
REQ-031 On a clock edge with rst=0, all state is forced regardless of other inputs: FSM=IDLE, timer=0, running count=0, win_valid=0, win_count=0, alarm=0, last_y=2'b00, overrun=0.
REQ-032 Reset mid-window or while a result is pending discards all results; no handshake is owed after reset.

Structure
REQ-033 The FSM state encoding (IDLE, COUNT) and the default parameter constants live in a shared package.
REQ-034 The saturating counter is one sub-module, sat_counter (parameter CNT_W; ports clk, rst, clr, inc, q).

Verification (WIN_LEN=8, THRESH=3, CNT_W=8)
REQ-035 Basic window: en=1 with z_in high on window cycles 1, 3, 7 and win_ready=1 -> one cycle with win_valid=1, win_count=3, alarm=1.
REQ-036 Boundary: z_in high on window cycle 7 and on cycle 0 of the next window -> first result 1 and second result 1, both with alarm=0.
REQ-037 Backpressure: win_ready=0 across two full windows -> the first result is held, overrun=1; then clr=1 for one cycle -> overrun=0.
REQ-038 Saturation: CNT_W=2, z_in high for all 8 cycles -> win_count=3 (no wrap).
REQ-039 Abort and reset: en=0 at window cycle 4 -> IDLE with no win_valid; also, rst=0 while win_valid=1 -> all outputs 0 on the next edge.
REQ-040 Upstream link: drive the Mealy detector with the sequence A = 1,0,1,0,1,1,1 -> win_count equals the number of Z pulses, and last_y equals the detector's y at the final Z pulse.
